// File: rtl/mips_alu_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module mips_alu_muldiv #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int W     = DATA_W;
    localparam int B     = BITS_PER_CYCLE;
    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_r_q, neg_r_d;
    logic             zdiv_q, zdiv_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d;

    logic             op_signed;
    logic [W-1:0]     mag1, mag2;
    logic [W+B-1:0]   mul_sum;
    logic [2*W+B-1:0] mul_wide;
    logic [W-1:0]     rem, quo;
    logic [W:0]       trial;
    logic [2*W-1:0]   mul_res;
    logic [W-1:0]     quo_res, rem_res;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mag1      = (op_signed && data1[W-1]) ? -data1 : data1;
    assign mag2      = (op_signed && data2[W-1]) ? -data2 : data2;

    // acc = {partial product, remaining multiplier bits}; B multiplier bits retire per edge
    assign mul_sum  = {{B{1'b0}}, acc_q[2*W-1:W]}
                    + ({{B{1'b0}}, opnd_q} * (W+B)'(acc_q[B-1:0]));
    assign mul_wide = {mul_sum, acc_q[W-1:0]};

    // acc = {partial remainder, dividend bits shifting into quotient}
    always_comb begin
        rem   = acc_q[2*W-1:W];
        quo   = acc_q[W-1:0];
        trial = '0;
        for (int i = 0; i < B; i++) begin
            trial = {rem, quo[W-1]} - {1'b0, opnd_q};
            if (!trial[W]) begin
                rem = trial[W-1:0];
                quo = {quo[W-2:0], 1'b1};
            end else begin
                rem = {rem[W-2:0], quo[W-1]};
                quo = {quo[W-2:0], 1'b0};
            end
        end
    end

    assign mul_res = neg_q   ? -acc_q          : acc_q;
    assign quo_res = neg_q   ? -acc_q[W-1:0]   : acc_q[W-1:0];
    assign rem_res = neg_r_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        zdiv_d   = zdiv_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: begin
                            hi_d   = data1;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = data1;
                            done_d = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {{W{1'b0}}, mag2};
                            opnd_d   = mag1;
                            neg_d    = op_signed && (data1[W-1] ^ data2[W-1]);
                            is_div_d = 1'b0;
                            zdiv_d   = 1'b0;
                            cnt_d    = CNT_W'(N);
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d = 1'b1;
                            if (data2 == '0) begin
                                // result preloaded so FIX writes it unchanged
                                acc_d   = {data1, {W{1'b1}}};
                                neg_d   = 1'b0;
                                neg_r_d = 1'b0;
                                zdiv_d  = 1'b1;
                                state_d = S_FIX;
                            end else begin
                                acc_d   = {{W{1'b0}}, mag1};
                                opnd_d  = mag2;
                                neg_d   = op_signed && (data1[W-1] ^ data2[W-1]);
                                neg_r_d = op_signed && data1[W-1];
                                zdiv_d  = 1'b0;
                                cnt_d   = CNT_W'(N);
                                state_d = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_wide[2*W+B-1:B] : {rem, quo};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[2*W-1:W];
                        lo_d = mul_res[W-1:0];
                    end
                    done_d = 1'b1;
                    dbz_d  = zdiv_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            zdiv_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            zdiv_q   <= zdiv_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Bench for mips_alu_muldiv: default 32-bit/1-bit-per-cycle instance and a 16-bit/2-bit instance,
// checked against an arithmetic reference model of HI/LO.
module tb_mips_alu_muldiv;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        start_a, cancel_a, busy_a, done_a, dbz_a;
    logic [2:0]  op_a;
    logic [31:0] d1_a, d2_a, hi_a, lo_a;
    logic        start_b, cancel_b, busy_b, done_b, dbz_b;
    logic [2:0]  op_b;
    logic [15:0] d1_b, d2_b, hi_b, lo_b;

    mips_alu_muldiv #(.DATA_W(32), .BITS_PER_CYCLE(1)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .op(op_a), .data1(d1_a), .data2(d2_a),
        .cancel(cancel_a), .busy(busy_a), .done(done_a), .div_by_zero(dbz_a), .hi(hi_a), .lo(lo_a));

    mips_alu_muldiv #(.DATA_W(16), .BITS_PER_CYCLE(2)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .op(op_b), .data1(d1_b), .data2(d2_b),
        .cancel(cancel_b), .busy(busy_b), .done(done_b), .div_by_zero(dbz_b), .hi(hi_b), .lo(lo_b));

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_hi [2];
    logic [63:0] exp_lo [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic o_done(input bit sel); return sel ? done_b : done_a; endfunction
    function automatic logic o_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
    function automatic logic o_dbz(input bit sel);  return sel ? dbz_b  : dbz_a;  endfunction
    function automatic logic [63:0] o_hi(input bit sel);
        return sel ? {48'b0, hi_b} : {32'b0, hi_a};
    endfunction
    function automatic logic [63:0] o_lo(input bit sel);
        return sel ? {48'b0, lo_b} : {32'b0, lo_a};
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic cn);
        if (sel) begin
            start_b = st; op_b = op; d1_b = a[15:0]; d2_b = b[15:0]; cancel_b = cn;
        end else begin
            start_a = st; op_a = op; d1_a = a; d2_a = b; cancel_a = cn;
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands (SV / and % truncate toward zero)
    function automatic void model(input int w, input int op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] h, input logic [63:0] l,
                                  output logic [63:0] nh, output logic [63:0] nl, output bit dz);
        logic [63:0] mask, pu;
        longint sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = $signed(a << (64 - w)) >>> (64 - w);
        sb = $signed(b << (64 - w)) >>> (64 - w);
        nh = h; nl = l; dz = 1'b0;
        case (op)
            1: begin p = sa * sb; pu = p; nh = (pu >> w) & mask; nl = pu & mask; end
            2: begin pu = a * b; nh = (pu >> w) & mask; nl = pu & mask; end
            3, 4: begin
                if (b == 0) begin
                    nh = a; nl = mask; dz = 1'b1;
                end else if (op == 3) begin
                    q = sa / sb; r = sa % sb;
                    nh = r & mask; nl = q & mask;
                end else begin
                    nh = a % b; nl = a / b;
                end
            end
            5: nh = a;
            6: nl = a;
            default: ;
        endcase
    endfunction

    task automatic issue(input bit sel, input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic cn = 1'b0);
        drive(sel, 1'b1, 3'(op), a, b, cn);
        tick();
        drive(sel, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // Called just after the accept edge. inj_kind: 1 = stray MTHI start, 2 = cancel, at sample inj_at.
    task automatic await_op(input bit sel, input int op, input logic [31:0] a_in, input logic [31:0] b_in,
                            input int inj_at = -1, input int inj_kind = 0, input bit keep = 1'b0);
        int w = sel ? 16 : 32;
        int n = sel ? 8 : 32;
        logic [63:0] a, b, eh, el;
        bit dz, canceled, seen;
        int exp_lat, lat, busy_cnt;
        a = {32'b0, a_in} & ((64'd1 << w) - 64'd1);
        b = {32'b0, b_in} & ((64'd1 << w) - 64'd1);
        model(w, op, a, b, exp_hi[sel], exp_lo[sel], eh, el, dz);
        if (op < 1 || op > 6) begin
            repeat (3) begin
                chk("nop_done", o_done(sel), 1'b0);
                chk("nop_busy", o_busy(sel), 1'b0);
                tick();
            end
            chk("nop_hi", o_hi(sel), exp_hi[sel]);
            chk("nop_lo", o_lo(sel), exp_lo[sel]);
            return;
        end
        exp_lat  = (op >= 5) ? 0 : ((op <= 4 && op >= 3 && b == 0) ? 1 : n + 1);
        lat      = 0;
        busy_cnt = 0;
        canceled = 1'b0;
        while (!o_done(sel) && lat < 100) begin
            if (o_busy(sel)) busy_cnt++;
            if (lat == inj_at && inj_kind == 1) drive(sel, 1'b1, 3'd5, 32'h1234, 32'd0, 1'b0);
            if (lat == inj_at && inj_kind == 2) drive(sel, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
            tick();
            drive(sel, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            lat++;
            if (lat == inj_at + 1 && inj_kind == 2) begin
                canceled = 1'b1;
                break;
            end
        end
        if (canceled) begin
            chk("cancel_done", o_done(sel), 1'b0);
            chk("cancel_busy", o_busy(sel), 1'b0);
            seen = 1'b0;
            repeat (n + 8) begin
                if (o_done(sel)) seen = 1'b1;
                tick();
            end
            chk("cancel_no_late_done", seen, 1'b0);
            chk("cancel_hi", o_hi(sel), exp_hi[sel]);
            chk("cancel_lo", o_lo(sel), exp_lo[sel]);
            return;
        end
        chk("done_seen", o_done(sel), 1'b1);
        chk("latency", lat, exp_lat);
        chk("busy_cycles", busy_cnt, exp_lat);
        chk("busy_at_done", o_busy(sel), 1'b0);
        chk("hi", o_hi(sel), eh);
        chk("lo", o_lo(sel), el);
        chk("div_by_zero", o_dbz(sel), dz);
        exp_hi[sel] = eh;
        exp_lo[sel] = el;
        if (!keep) begin
            tick();
            chk("done_pulse", o_done(sel), 1'b0);
            chk("dbz_pulse", o_dbz(sel), 1'b0);
            chk("hi_hold", o_hi(sel), eh);
            chk("lo_hold", o_lo(sel), el);
        end
    endtask

    task automatic run(input bit sel, input int op, input logic [31:0] a, input logic [31:0] b);
        issue(sel, op, a, b);
        await_op(sel, op, a, b);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int rop;
        bit seen;

        reset = 1'b0;
        drive(0, 1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom));
        drive(1, 1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom));
        #23;
        for (int s = 0; s < 2; s++) begin
            chk("rst_hi", o_hi(s[0]), 64'd0);
            chk("rst_lo", o_lo(s[0]), 64'd0);
            chk("rst_busy", o_busy(s[0]), 1'b0);
            chk("rst_done", o_done(s[0]), 1'b0);
            chk("rst_dbz", o_dbz(s[0]), 1'b0);
            exp_hi[s] = 64'd0;
            exp_lo[s] = 64'd0;
        end
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #1 reset = 1'b1;
        tick();

        run(0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(0, 1, 32'hFFFF_FFFD, 32'd5);
        run(0, 3, 32'hFFFF_FFF9, 32'd2);
        run(0, 4, 32'd100, 32'd7);
        run(0, 3, 32'h8000_0000, 32'hFFFF_FFFF);
        run(0, 4, 32'd5, 32'd0);
        run(0, 3, 32'hFFFF_FFF0, 32'd0);
        run(0, 6, 32'h0000_ABCD, 32'd0);
        run(0, 5, 32'h0000_5678, 32'd0);
        run(0, 0, 32'h1111_1111, 32'd3);
        run(0, 7, 32'h2222_2222, 32'd3);

        issue(0, 1, 32'h0001_0003, 32'hFFFF_FFF9);
        await_op(0, 1, 32'h0001_0003, 32'hFFFF_FFF9, 5, 1);
        issue(0, 3, 32'd1000, 32'd3);
        await_op(0, 3, 32'd1000, 32'd3, 10, 2);
        issue(0, 2, 32'hDEAD_BEEF, 32'h1234_5678);
        await_op(0, 2, 32'hDEAD_BEEF, 32'h1234_5678, 32, 2);
        issue(0, 6, 32'h0000_0055, 32'd0, 1'b1);
        await_op(0, 6, 32'h0000_0055, 32'd0);

        for (int i = 0; i < 20; i++) begin
            rop = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 4) == 0) rb = 32'hFFFF_FFFF;
            run(0, rop, ra, rb);
        end

        issue(0, 1, 32'h7FFF_0001, 32'h0000_0101);
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_hi", o_hi(0), 64'd0);
        chk("midrst_lo", o_lo(0), 64'd0);
        chk("midrst_busy", o_busy(0), 1'b0);
        chk("midrst_done", o_done(0), 1'b0);
        exp_hi[0] = 64'd0; exp_lo[0] = 64'd0;
        exp_hi[1] = 64'd0; exp_lo[1] = 64'd0;
        #2 reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done_a || busy_a) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 1'b0);

        run(1, 2, 32'h0000_FFFF, 32'h0000_0002);
        issue(1, 1, 32'h0000_FFFD, 32'h0000_0007);
        await_op(1, 1, 32'h0000_FFFD, 32'h0000_0007, -1, 0, 1'b1);
        issue(1, 3, 32'h0000_8000, 32'h0000_FFFF);
        await_op(1, 3, 32'h0000_8000, 32'h0000_FFFF);
        run(1, 3, 32'h0000_FFF9, 32'h0000_0002);
        run(1, 4, 32'h0000_0009, 32'h0000_0000);
        for (int i = 0; i < 12; i++) begin
            rop = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run(1, rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
